// File: rtl/encoder_quad_decoder_if.sv
// Pin-side bundle of the quadrature decoder: raw encoder channels in, event/direction/position/phase out.
// enable is a one-cycle event code with no backpressure; consumers must sample it every cycle.
interface encoder_quad_decoder_if #(
  parameter int POS_W = 16
);
  logic             enc_a;
  logic             enc_b;
  logic [1:0]       enable;
  logic             dir;
  logic [POS_W-1:0] position;
  logic [1:0]       phase;

  modport master (
    output enc_a, enc_b,
    input  enable, dir, position, phase
  );

  modport slave (
    input  enc_a, enc_b,
    output enable, dir, position, phase
  );
endinterface

// File: rtl/encoder_quad_decoder.sv
// Quadrature encoder decoder: 2-flop sync, per-channel debounce, quarter-step accumulation, detent events.
// Optional macro ENCODER_POS_SAT_EN makes the position counter saturate instead of wrapping.
module encoder_quad_decoder #(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int POS_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  encoder_quad_decoder_if.slave bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_MAX  = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN  = {1'b1, {(POS_W-1){1'b0}}};
`ifdef ENCODER_POS_SAT_EN
  localparam bit POS_SAT = 1'b1;
`else
  localparam bit POS_SAT = 1'b0;
`endif

  localparam logic signed [3:0] ACC_CW  = 4'sd4;
  localparam logic signed [3:0] ACC_CCW = -4'sd4;

  // Bit 1 is channel A, bit 0 is channel B throughout.
  logic [1:0]            sync1_q, sync2_q, deb_q;
  logic [1:0][CNT_W-1:0] cnt_q;

  logic [1:0]       prev_q;
  logic signed [3:0] acc_q, acc_d, acc_step;
  logic [1:0]       enable_q, enable_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       step;

  // Position of a phase along the CW cycle 00->01->11->10, so a step is a difference mod 4.
  function automatic logic [1:0] quad_idx(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {bus.enc_a, bus.enc_b};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_q[i] <= ~deb_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    enable_d = 2'b00;
    dir_d    = dir_q;
    pos_d    = pos_q;
    acc_d    = acc_q;
    acc_step = acc_q;
    step     = quad_idx(deb_q) - quad_idx(prev_q);

    case (step)
      2'd1:    if (acc_q != ACC_CW)  acc_step = acc_q + 4'sd1;
      2'd3:    if (acc_q != ACC_CCW) acc_step = acc_q - 4'sd1;
      default: acc_step = acc_q;
    endcase

    if (step == 2'd2) begin
      enable_d = 2'b10;
      acc_d    = '0;
    end else if (step != 2'd0) begin
      if (deb_q == 2'b00) begin
        // Back at a detent: only a full four-quarter turn in one direction counts.
        acc_d = '0;
        if (acc_step == ACC_CW) begin
          enable_d = 2'b01;
          dir_d    = 1'b1;
          if (!(POS_SAT && pos_q == POS_MAX)) pos_d = pos_q + 1'b1;
        end else if (acc_step == ACC_CCW) begin
          enable_d = 2'b01;
          dir_d    = 1'b0;
          if (!(POS_SAT && pos_q == POS_MIN)) pos_d = pos_q - 1'b1;
        end
      end else begin
        acc_d = acc_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 2'b00;
      acc_q    <= '0;
      enable_q <= 2'b00;
      dir_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      prev_q   <= deb_q;
      acc_q    <= acc_d;
      enable_q <= enable_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
    end
  end

  assign bus.enable   = enable_q;
  assign bus.dir      = dir_q;
  assign bus.position = pos_q;
  assign bus.phase    = deb_q;

endmodule

// File: tb/tb_encoder_quad_decoder.sv
// Bench for encoder_quad_decoder with a short debounce window and a 4-bit position counter.
// Honours ENCODER_POS_SAT_EN the same way the design does.
module tb_encoder_quad_decoder;

  localparam int DEB   = 4;
  localparam int POS_W = 4;
  localparam int W     = 2 + 1 + POS_W;
  localparam int PMAX  = (1 << (POS_W - 1)) - 1;
  localparam int PMIN  = -(1 << (POS_W - 1));

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  encoder_quad_decoder_if #(.POS_W(POS_W)) bus ();

  encoder_quad_decoder #(.DEBOUNCE_CYCLES(DEB), .POS_W(POS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: rotation angle in quarter turns, accumulated since the last detent.
  int angle_of[4] = '{0, 1, 3, 2};
  logic [1:0] m_ab;
  int m_acc, m_pos;
  logic m_dir;

  typedef struct {
    logic [1:0] ab;
    logic [1:0] exp_code;
    logic       exp_dir;
    int         exp_pos;
  } vec_t;
  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [POS_W-1:0] pbits(input int p);
    logic [31:0] t;
    t = p;
    return t[POS_W-1:0];
  endfunction

  function automatic int bump(input int p, input int d);
    int r;
    r = p + d;
`ifdef ENCODER_POS_SAT_EN
    if (r > PMAX) r = PMAX;
    if (r < PMIN) r = PMIN;
`else
    if (r > PMAX) r = PMIN;
    if (r < PMIN) r = PMAX;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_ab = 2'b00; m_acc = 0; m_pos = 0; m_dir = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] ab);
    int d;
    d = (angle_of[ab] - angle_of[m_ab] + 4) % 4;
    if (d == 2) begin
      m_acc = 0;
      exp_q.push_back({2'b10, m_dir, pbits(m_pos)});
    end else if (d != 0) begin
      m_acc = (d == 1) ? m_acc + 1 : m_acc - 1;
      if (m_acc > 4) m_acc = 4;
      if (m_acc < -4) m_acc = -4;
      if (ab == 2'b00) begin
        if (m_acc == 4 || m_acc == -4) begin
          m_dir = (m_acc == 4);
          m_pos = bump(m_pos, m_dir ? 1 : -1);
          exp_q.push_back({2'b01, m_dir, pbits(m_pos)});
        end
        m_acc = 0;
      end
    end
    m_ab = ab;
  endtask

  task automatic drive(input logic [1:0] ab);
    bus.enc_a = ab[1];
    bus.enc_b = ab[0];
  endtask

  task automatic check_state(input string tag);
    check({tag, "_phase"}, 32'(bus.phase), 32'(m_ab));
    check({tag, "_dir"}, 32'(bus.dir), 32'(m_dir));
    check({tag, "_pos"}, 32'(bus.position), 32'(pbits(m_pos)));
  endtask

  task automatic apply_phase(input logic [1:0] ab, input int hold, input string tag);
    drive(ab);
    model_step(ab);
    repeat (hold) @(negedge clk);
    check_state(tag);
  endtask

  task automatic glitch_to(input logic [1:0] ab);
    logic [1:0] old;
    old = m_ab;
    drive(ab);
    repeat (3) @(negedge clk);
    drive(old);
    repeat (2) @(negedge clk);
    apply_phase(ab, 20, "glitch");
  endtask

  task automatic reset_dut(input logic [1:0] ab);
    rst_n = 1'b0;
    drive(ab);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Every non-idle enable cycle must match the next expected event exactly.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n === 1'b1 && bus.enable !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got enable=%b pos=%0h, expected none at %0t",
                 bus.enable, bus.position, $time);
      end else begin
        e = exp_q.pop_front();
        check("event", 32'({bus.enable, bus.dir, bus.position}), 32'(e));
      end
    end
  end

  initial begin
    vecs[0]  = '{2'b01, 2'b00, 1'b0, 0};
    vecs[1]  = '{2'b11, 2'b00, 1'b0, 0};
    vecs[2]  = '{2'b10, 2'b00, 1'b0, 0};
    vecs[3]  = '{2'b00, 2'b01, 1'b1, 1};
    vecs[4]  = '{2'b10, 2'b00, 1'b1, 1};
    vecs[5]  = '{2'b11, 2'b00, 1'b1, 1};
    vecs[6]  = '{2'b01, 2'b00, 1'b1, 1};
    vecs[7]  = '{2'b00, 2'b01, 1'b0, 0};
    vecs[8]  = '{2'b01, 2'b00, 1'b0, 0};
    vecs[9]  = '{2'b11, 2'b00, 1'b0, 0};
    vecs[10] = '{2'b01, 2'b00, 1'b0, 0};
    vecs[11] = '{2'b00, 2'b00, 1'b0, 0};
    vecs[12] = '{2'b11, 2'b10, 1'b0, 0};
    vecs[13] = '{2'b10, 2'b00, 1'b0, 0};
    vecs[14] = '{2'b00, 2'b00, 1'b0, 0};
    vecs[15] = '{2'b01, 2'b00, 1'b0, 0};
    vecs[16] = '{2'b11, 2'b00, 1'b0, 0};
    vecs[17] = '{2'b10, 2'b00, 1'b0, 0};
    vecs[18] = '{2'b00, 2'b01, 1'b1, 1};

    rst_n = 1'b0;
    drive(2'b00);
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      drive(2'($urandom_range(0, 3)));
      @(negedge clk);
      check("rst_enable", 32'(bus.enable), 32'd0);
      check("rst_dir", 32'(bus.dir), 32'd0);
      check("rst_pos", 32'(bus.position), 32'd0);
      check("rst_phase", 32'(bus.phase), 32'd0);
    end
    drive(2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_pos", 32'(bus.position), 32'd0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].ab);
      if (vecs[i].exp_code != 2'b00)
        exp_q.push_back({vecs[i].exp_code, vecs[i].exp_dir, pbits(vecs[i].exp_pos)});
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_phase", i), 32'(bus.phase), 32'(vecs[i].ab));
      check($sformatf("vec%0d_dir", i), 32'(bus.dir), 32'(vecs[i].exp_dir));
      check($sformatf("vec%0d_pos", i), 32'(bus.position), 32'(pbits(vecs[i].exp_pos)));
    end

    // Latency of the final detent edge: phase after 2+DEB cycles, pulse one cycle later.
    reset_dut(2'b00);
    apply_phase(2'b01, 20, "lat");
    apply_phase(2'b11, 20, "lat");
    apply_phase(2'b10, 20, "lat");
    drive(2'b00);
    model_step(2'b00);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5) check("lat_phase_before", 32'(bus.phase), 32'b10);
      if (i == 6) check("lat_phase_at", 32'(bus.phase), 32'b00);
      check($sformatf("lat_enable_c%0d", i), 32'(bus.enable), (i == 7) ? 32'd1 : 32'd0);
    end
    repeat (10) @(negedge clk);
    check_state("lat_end");

    // CCW detent with short glitches on every edge.
    reset_dut(2'b00);
    glitch_to(2'b10);
    glitch_to(2'b11);
    glitch_to(2'b01);
    glitch_to(2'b00);
    check("ccw_pos", 32'(bus.position), 32'(pbits(-1)));
    check("ccw_dir", 32'(bus.dir), 32'd0);

    // Reset three quarters into a CW turn: the partial accumulation is lost.
    reset_dut(2'b00);
    apply_phase(2'b01, 20, "mid");
    apply_phase(2'b11, 20, "mid");
    apply_phase(2'b10, 20, "mid");
    reset_dut(2'b10);
    model_step(2'b10);
    repeat (20) @(negedge clk);
    apply_phase(2'b00, 20, "mid_after");
    check("mid_pos", 32'(bus.position), 32'd0);

    // Eight CW detents run the 4-bit counter past its positive limit.
    reset_dut(2'b00);
    for (int k = 0; k < 8; k++) begin
      apply_phase(2'b01, 8, "wrap");
      apply_phase(2'b11, 8, "wrap");
      apply_phase(2'b10, 8, "wrap");
      apply_phase(2'b00, 8, "wrap");
    end
`ifdef ENCODER_POS_SAT_EN
    check("wrap_final", 32'(bus.position), 32'(pbits(7)));
`else
    check("wrap_final", 32'(bus.position), 32'(pbits(-8)));
`endif

    reset_dut(2'b00);
    for (int k = 0; k < 120; k++)
      apply_phase(2'($urandom_range(0, 3)), $urandom_range(8, 16), "rand");

    repeat (20) @(negedge clk);
    check("events_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_quad_decoder.md
Name: encoder_quad_decoder

Overview:
- Decodes a mechanical quadrature rotary encoder (channels A/B) into one-cycle step events and a direction flag for the LED animation block.
- Also keeps a signed position count.
- Sits between the board encoder pins and the animation / stepper-control logic.
- Emits the 2-bit event code that the animation block consumes: 2'b01 starts an animation.

Parameters:
- DEBOUNCE_CYCLES, 50_000, consecutive stable clk cycles required before a synchronized input is accepted (1 ms at 50 MHz); minimum 1.
- POS_W, 16, width of the signed position counter.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- enc_a  input  1  encoder channel A, asynchronous to clk, bouncy
- enc_b  input  1  encoder channel B, asynchronous to clk, bouncy
- enable  output  2  event code, one-cycle pulses: 2'b00 idle, 2'b01 valid detent step, 2'b10 illegal transition; 2'b11 never driven
- dir  output  1  direction of the last valid step: 1 = clockwise (right sweep), 0 = counter-clockwise
- position  output  POS_W  signed detent count, two's complement
- phase  output  2  current debounced {A,B}

Behaviour:
- Reset (async, rst_n=0): enable=2'b00, dir=0, position=0, phase=2'b00, accumulator=0, debounce counters=0, synchronizer flops=0.
  - Release is clean on the next clk edge.
  - A reset mid-rotation discards any partial accumulation.
- Synchronizer: each of enc_a and enc_b passes through 2 flops.
- Debounce, independent per channel:
  - A counter increments while the synced bit differs from its debounced bit.
  - The counter clears whenever the two are equal.
  - When the count reaches DEBOUNCE_CYCLES-1 while still differing, the debounced bit toggles on that edge and the counter clears.
  - Width is sized for DEBOUNCE_CYCLES.
- Latency: a clean input edge reaches phase 2 + DEBOUNCE_CYCLES cycles later. enable/dir/position update 1 cycle after phase.
- Quarter-step decode compares the previous phase with the new phase each cycle:
  - Clockwise (CW) sequence: 00->01->11->10->00. Each CW quarter step adds +1 to the accumulator (signed 4-bit).
  - Counter-clockwise (CCW), the reverse sequence: each quarter step adds -1.
  - No change: nothing happens.
  - Both bits change in the same cycle: illegal. enable=2'b10 for 1 cycle, accumulator clears, dir and position are unchanged.
- Detent decision, taken when the phase enters 00:
  - accumulator = +4: enable=2'b01, dir=1, position+1.
  - accumulator = -4: enable=2'b01, dir=0, position-1.
  - Any other value (partial turn or jitter back to the detent): no event.
  - In all three cases the accumulator clears.
- Accumulator saturates at ±4; further quarter steps away from 00 cannot occur without passing 00, so beyond ±4 it holds.
- dir holds its value between steps. enable returns to 2'b00 the cycle after any pulse.
- Position wraps: the maximum positive value +1 becomes the minimum negative value, and vice versa.
- Back-to-back detents (possible only when DEBOUNCE_CYCLES is small) each produce their own pulse. No pulse is merged or dropped.

Optional Feature:
- Macro: ENCODER_POS_SAT_EN
- Defined: position saturates at 2^(POS_W-1)-1 and -2^(POS_W-1) instead of wrapping. enable and dir still pulse and update at the limit.
- Undefined: two's-complement wrap as described in Behaviour.

Test Plan:
- Reset: hold rst_n=0 with the inputs toggling -> enable=00, dir=0, position=0, phase=00 throughout; the first event appears only after release.
- CW detent (DEBOUNCE_CYCLES=4): drive {A,B} 00->01->11->10->00, each held 20 cycles -> exactly one enable=01 pulse, 1 cycle wide, 7 cycles after the final 00 is applied; dir=1; position=1.
- CCW then bounce: drive 00->10->11->01->00 with 3-cycle glitches on every edge -> exactly one enable=01 pulse, dir=0, position=-1; no pulses from the glitches.
- Partial turn: 00->01->11->01->00 -> no enable pulse; position and dir unchanged.
- Illegal: 00->11 applied in the same cycle -> enable=10 for 1 cycle; a following full CW sequence then yields enable=01, position+1.
- Wrap/saturate (POS_W=4): 8 CW detents from 0 -> position=-8 without the macro, 7 with ENCODER_POS_SAT_EN; enable=01 pulses on all 8 in both builds.
